// File: rtl/m_axi_burst_writer_if.sv
// ---------------------------------------------------------------------------
// m_axi_burst_writer_if : AXI3 write-channel bundle (AW, W, B)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface m_axi_burst_writer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [3:0]              awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [3:0]              wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

`default_nettype wire

// File: rtl/m_axi_burst_writer.sv
// ---------------------------------------------------------------------------
// m_axi_burst_writer : snapshots NUM_WORDS words and writes them as INCR bursts
// Optional macro M_AXI_BURST_RETRY_EN reissues failed bursts up to MAX_RETRY.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m_axi_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int NUM_WORDS  = 6,
  parameter int MAX_BURST  = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_RETRY  = 2
) (
  input  wire logic                            clk,
  input  wire logic                            areset,
  input  wire logic                            start_i,
  input  wire logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  wire logic [NUM_WORDS*DATA_WIDTH-1:0] words_i,
  output logic [2:0]                           status_o,
  output logic                                 done_o,
  m_axi_burst_writer_if.master                 axi
);

  localparam int c_IW   = $clog2(NUM_WORDS + 1);
  localparam int c_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [7:0] c_MAX_RETRY = 8'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                          r_state, w_next;
  logic [NUM_WORDS*DATA_WIDTH-1:0] r_snap;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [c_IW-1:0]                 r_idx;
  logic [3:0]                      r_beat;
  logic [3:0]                      r_awlen;
  logic                            r_err, r_done, r_done_pulse;

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_b_ok, w_last_beat, w_all_sent, w_can_retry;
  logic [c_IW-1:0]       w_idx_nxt;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [31:0]           w_off;

  // Length of the burst that starts at word idx: remainder capped at MAX_BURST
  function automatic logic [3:0] f_len(input logic [c_IW-1:0] idx);
    int rem;
    rem = NUM_WORDS - int'(idx);
    if (rem > MAX_BURST) return 4'(MAX_BURST - 1);
    return 4'(rem - 1);
  endfunction

  assign w_aw_hs     = (r_state == S_ADDR) && axi.awready;
  assign w_w_hs      = (r_state == S_DATA) && axi.wready;
  assign w_b_hs      = (r_state == S_RESP) && axi.bvalid;
  assign w_b_ok      = (axi.bresp == 2'b00);
  assign w_last_beat = (r_beat == r_awlen);
  assign w_idx_nxt   = r_idx + c_IW'(5'(r_awlen) + 5'd1);
  assign w_all_sent  = int'(w_idx_nxt) >= NUM_WORDS;
  assign w_step      = ADDR_WIDTH'(5'(r_awlen) + 5'd1) << c_SIZE;
  assign w_off       = (32'(r_idx) + 32'(r_beat)) * 32'(DATA_WIDTH);

`ifdef M_AXI_BURST_RETRY_EN
  logic [7:0] r_retry;
  logic       w_unused_cfg;
  assign w_can_retry  = (r_retry < c_MAX_RETRY);
  assign w_unused_cfg = ^axi.bid;
`else
  logic w_unused_cfg;
  assign w_can_retry  = 1'b0;
  assign w_unused_cfg = ^{axi.bid, c_MAX_RETRY};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_ADDR;
      S_ADDR: if (w_aw_hs) w_next = S_DATA;
      S_DATA: if (w_w_hs && w_last_beat) w_next = S_RESP;
      S_RESP: begin
        if (w_b_hs) begin
          if (w_b_ok)           w_next = w_all_sent ? S_IDLE : S_ADDR;
          else if (w_can_retry) w_next = S_ADDR;
          else                  w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_addr       <= '0;
      r_idx        <= '0;
      r_beat       <= '0;
      r_awlen      <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
`ifdef M_AXI_BURST_RETRY_EN
      r_retry      <= '0;
`endif
    end else begin
      r_state      <= w_next;
      r_done_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_snap  <= words_i;
            r_addr  <= base_addr_i;
            r_idx   <= '0;
            r_beat  <= '0;
            r_awlen <= f_len('0);
            r_err   <= 1'b0;
            r_done  <= 1'b0;
`ifdef M_AXI_BURST_RETRY_EN
            r_retry <= '0;
`endif
          end
        end
        S_DATA: begin
          if (w_w_hs) r_beat <= w_last_beat ? 4'd0 : r_beat + 4'd1;
        end
        S_RESP: begin
          if (w_b_hs) begin
            if (w_b_ok) begin
              r_addr  <= r_addr + w_step;
              r_idx   <= w_idx_nxt;
              r_awlen <= w_all_sent ? r_awlen : f_len(w_idx_nxt);
`ifdef M_AXI_BURST_RETRY_EN
              r_retry <= '0;
`endif
              if (w_all_sent) begin
                r_done       <= 1'b1;
                r_done_pulse <= 1'b1;
              end
            end else if (w_can_retry) begin
`ifdef M_AXI_BURST_RETRY_EN
              r_retry <= r_retry + 8'd1;
`endif
            end else begin
              r_err        <= 1'b1;
              r_done       <= 1'b1;
              r_done_pulse <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign axi.awid    = 4'(AXI_ID);
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = r_awlen;
  assign axi.awsize  = 3'(c_SIZE);
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (r_state == S_ADDR);
  assign axi.wid     = 4'(AXI_ID);
  assign axi.wdata   = r_snap[w_off +: DATA_WIDTH];
  assign axi.wstrb   = '1;
  assign axi.wlast   = (r_state == S_DATA) && w_last_beat;
  assign axi.wvalid  = (r_state == S_DATA);
  assign axi.bready  = (r_state == S_RESP);

  assign status_o = {r_err, r_done, r_state != S_IDLE};
  assign done_o   = r_done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_m_axi_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_m_axi_burst_writer : table-driven, randomized bench with a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_m_axi_burst_writer;
  localparam int NW = 6;
  localparam int MB = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic               start_i;
  logic [63:0]        base_i;
  logic [NW*DW-1:0]   words_i;
  logic [2:0]         status;
  logic               done;
  m_axi_burst_writer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(DW)) axi1 ();

  m_axi_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(64), .NUM_WORDS(NW), .MAX_BURST(MB),
                       .AXI_ID(0), .MAX_RETRY(2)) u_dut (
    .clk(clk), .areset(areset), .start_i(start_i), .base_addr_i(base_i),
    .words_i(words_i), .status_o(status), .done_o(done), .axi(axi1));

  // Single-word instance for the one-beat edge case
  logic        start2;
  logic [63:0] base2;
  logic [31:0] words2;
  logic [2:0]  status2;
  logic        done2;
  m_axi_burst_writer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(DW)) axi2 ();

  m_axi_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(64), .NUM_WORDS(1), .MAX_BURST(16),
                       .AXI_ID(0), .MAX_RETRY(2)) u_dut2 (
    .clk(clk), .areset(areset), .start_i(start2), .base_addr_i(base2),
    .words_i(words2), .status_o(status2), .done_o(done2), .axi(axi2));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] base;
    int          rdy_p;
    int          err_at;
    int          nerr;
    bit          seq;
    bit          chg;
    bit          stray;
    int          exp_naw;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] mw[NW];
  logic [63:0] exp_aw_addr[$], got_aw_addr[$];
  logic [3:0]  exp_aw_len[$],  got_aw_len[$];
  logic [31:0] exp_w_data[$],  got_w_data[$];
  logic        exp_w_last[$],  got_w_last[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic rnd(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic bit is_err(input int k, input int err_at, input int nerr);
    return (err_at >= 0) && (k >= err_at) && (k < err_at + nerr);
  endfunction

  // Reference: walk the word list burst by burst, consuming one response per burst
  task automatic model(input logic [63:0] base, input int err_at, input int nerr, output logic err);
    int idx, k, tries, beats;
    logic [63:0] a;
    idx = 0; k = 0; tries = 0; a = base; err = 1'b0;
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_w_data.delete(); exp_w_last.delete();
    while (idx < NW) begin
      beats = (NW - idx > MB) ? MB : NW - idx;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(4'(beats - 1));
      for (int b = 0; b < beats; b++) begin
        exp_w_data.push_back(mw[idx + b]);
        exp_w_last.push_back(b == beats - 1);
      end
      if (!is_err(k, err_at, nerr)) begin
        a = a + 64'(beats * (DW / 8));
        idx = idx + beats;
        tries = 0;
        k++;
      end else begin
        k++;
`ifdef M_AXI_BURST_RETRY_EN
        if (tries < 2) tries++;
        else begin err = 1'b1; break; end
`else
        err = 1'b1;
        break;
`endif
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        exp_err;
    int          cyc, nb;
    bit          fin, aw_pend, w_pend;
    logic [68:0] aw_sav;
    logic [32:0] w_sav;
    got_aw_addr.delete(); got_aw_len.delete(); got_w_data.delete(); got_w_last.delete();
    cyc = 0; nb = 0; fin = 0; aw_pend = 0; w_pend = 0; aw_sav = '0; w_sav = '0;
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      mw[i] = v.seq ? 32'(i + 1) : $urandom;
      words_i[i*DW +: DW] = mw[i];
    end
    model(v.base, v.err_at, v.nerr, exp_err);
    base_i = v.base;
    start_i = 1'b1;
    axi1.awready = 1'b0; axi1.wready = 1'b0; axi1.bvalid = 1'b0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      if (cyc == 0) begin
        start_i = 1'b0;
        check("aw_latency", 96'(axi1.awvalid), 96'(1));
        if (v.chg) words_i = ~words_i;
      end
      if (v.stray && cyc == 3) begin start_i = 1'b1; base_i = 64'hDEAD_0000; end
      if (v.stray && cyc == 4) start_i = 1'b0;
      if (done) begin
        check("done_status", 96'(status), 96'(v.exp_st));
        check("done_model_status", 96'(status), 96'({exp_err, 2'b10}));
        fin = 1;
      end
      if (aw_pend) check("aw_hold", 96'({axi1.awvalid, axi1.awaddr, axi1.awlen}), 96'(aw_sav));
      axi1.awready = rnd(v.rdy_p);
      if (axi1.awvalid && axi1.awready) begin
        got_aw_addr.push_back(axi1.awaddr);
        got_aw_len.push_back(axi1.awlen);
      end
      aw_pend = axi1.awvalid && !axi1.awready;
      aw_sav  = {1'b1, axi1.awaddr, axi1.awlen};
      if (w_pend) check("w_hold", 96'({axi1.wvalid, axi1.wdata, axi1.wlast}), 96'({1'b1, w_sav}));
      axi1.wready = rnd(v.rdy_p);
      if (axi1.wvalid && axi1.wready) begin
        got_w_data.push_back(axi1.wdata);
        got_w_last.push_back(axi1.wlast);
      end
      w_pend = axi1.wvalid && !axi1.wready;
      w_sav  = {axi1.wdata, axi1.wlast};
      axi1.bresp  = is_err(nb, v.err_at, v.nerr) ? 2'b10 : 2'b00;
      axi1.bvalid = axi1.bready && rnd(v.rdy_p);
      if (axi1.bvalid) nb++;
      cyc++;
    end
    axi1.awready = 1'b0; axi1.wready = 1'b0; axi1.bvalid = 1'b0; start_i = 1'b0;
    if (!fin) check("done_timeout", 96'(0), 96'(1));
    @(negedge clk);
    check("done_one_cycle", 96'(done), 96'(0));
    check("status_sticky", 96'(status), 96'(v.exp_st));
    check("aw_count_table", 96'(got_aw_addr.size()), 96'(v.exp_naw));
    check("aw_count_model", 96'(got_aw_addr.size()), 96'(exp_aw_addr.size()));
    check("w_count_model", 96'(got_w_data.size()), 96'(exp_w_data.size()));
    for (int i = 0; i < exp_aw_addr.size() && i < got_aw_addr.size(); i++) begin
      check("aw_addr", 96'(got_aw_addr[i]), 96'(exp_aw_addr[i]));
      check("aw_len", 96'(got_aw_len[i]), 96'(exp_aw_len[i]));
    end
    for (int i = 0; i < exp_w_data.size() && i < got_w_data.size(); i++) begin
      check("w_data", 96'(got_w_data[i]), 96'(exp_w_data[i]));
      check("w_last", 96'(got_w_last[i]), 96'(exp_w_last[i]));
    end
  endtask

  initial begin
    vecs[0] = '{64'h1000, 100, -1, 0, 1'b1, 1'b0, 1'b0, 2, 3'b010};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF8, 100, -1, 0, 1'b0, 1'b0, 1'b0, 2, 3'b010};
    vecs[2] = '{64'h40, 40, -1, 0, 1'b0, 1'b1, 1'b0, 2, 3'b010};
    vecs[5] = '{64'h2000, 60, -1, 0, 1'b0, 1'b1, 1'b1, 2, 3'b010};
`ifdef M_AXI_BURST_RETRY_EN
    vecs[3] = '{64'h1000, 100, 0, 1, 1'b1, 1'b0, 1'b0, 3, 3'b010};
    vecs[4] = '{64'h1000, 100, 0, 3, 1'b1, 1'b0, 1'b0, 3, 3'b110};
    vecs[6] = '{64'h3000, 70, 1, 1, 1'b0, 1'b0, 1'b0, 3, 3'b010};
`else
    vecs[3] = '{64'h1000, 100, 0, 1, 1'b1, 1'b0, 1'b0, 1, 3'b110};
    vecs[4] = '{64'h1000, 100, 0, 3, 1'b1, 1'b0, 1'b0, 1, 3'b110};
    vecs[6] = '{64'h3000, 70, 1, 1, 1'b0, 1'b0, 1'b0, 2, 3'b110};
`endif

    areset = 1'b1; start_i = 1'b0; base_i = '0; words_i = '0;
    axi1.awready = 1'b0; axi1.wready = 1'b0; axi1.bvalid = 1'b0; axi1.bresp = 2'b00; axi1.bid = 4'd0;
    start2 = 1'b0; base2 = '0; words2 = '0;
    axi2.awready = 1'b1; axi2.wready = 1'b1; axi2.bvalid = 1'b1; axi2.bresp = 2'b00; axi2.bid = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 96'({axi1.awvalid, axi1.wvalid, axi1.wlast, axi1.bready, done, status}), 96'(0));
    check("rst_awaddr", 96'(axi1.awaddr), 96'(0));
    check("rst_awlen_wdata", 96'({axi1.awlen, axi1.wdata}), 96'(0));
    check("rst_const", 96'({axi1.awid, axi1.wid, axi1.awsize, axi1.awburst, axi1.wstrb}),
          96'({4'd0, 4'd0, 3'd2, 2'b01, 4'hF}));
    areset = 1'b0;

    for (int n = 0; n < 7; n++) begin
      run_vec(vecs[n]);
      if (n == 0) begin
        check("basic_aw0", 96'({got_aw_addr[0], got_aw_len[0]}), 96'({64'h1000, 4'd3}));
        check("basic_aw1", 96'({got_aw_addr[1], got_aw_len[1]}), 96'({64'h1010, 4'd1}));
        check("basic_wlast", 96'({got_w_last[0], got_w_last[2], got_w_last[3], got_w_last[4], got_w_last[5]}),
              96'(5'b00101));
        check("basic_wdata5", 96'(got_w_data[5]), 96'(6));
      end
    end

    // Reset in the middle of the data phase
    @(negedge clk);
    base_i = 64'h3000; start_i = 1'b1; axi1.awready = 1'b1; axi1.wready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 10 && !axi1.wvalid; i++) @(negedge clk);
    check("rst_mid_in_data", 96'(axi1.wvalid), 96'(1));
    areset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_wvalid", 96'({axi1.wvalid, axi1.awvalid, done}), 96'(0));
    check("rst_mid_status", 96'(status), 96'(0));
    @(negedge clk);
    areset = 1'b0; axi1.awready = 1'b0;
    run_vec(vecs[0]);

    // Single-word instance: one burst, awlen 0, wlast on the only beat
    @(negedge clk);
    start2 = 1'b1; base2 = 64'h5000; words2 = 32'hDEAD_BEEF;
    @(negedge clk);
    start2 = 1'b0;
    check("one_aw", 96'({axi2.awvalid, axi2.awaddr, axi2.awlen}), 96'({1'b1, 64'h5000, 4'd0}));
    @(negedge clk);
    check("one_w", 96'({axi2.wvalid, axi2.wlast, axi2.wdata}), 96'({2'b11, 32'hDEAD_BEEF}));
    @(negedge clk);
    check("one_b", 96'({axi2.bready, axi2.wvalid}), 96'(2'b10));
    @(negedge clk);
    check("one_done", 96'({done2, status2}), 96'({1'b1, 3'b010}));
    @(negedge clk);
    check("one_idle", 96'({done2, axi2.awvalid}), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
